// File: rtl/ternary_pkg.sv
// Shared constants and types for the radix-3 digit serializer.
// Optional leading-zero suppression is selected with the TERNARY_LZS_EN macro.
package ternary_pkg;

    localparam int W        = 16;
    localparam int N_DIGITS = 11;
    localparam int IDX_W    = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    typedef logic [1:0] trit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2
    } state_e;

endpackage

// File: rtl/div_16_3_stand.sv
// Combinational 16-bit unsigned divide-by-3 core: X = 3*Q + R.
// Restoring long division, one quotient bit per stage from the MSB down.
module div_16_3_stand (
    input  logic [15:0] X,
    output logic [14:0] Q,
    output logic [1:0]  R
);

    // rem[0] is the remainder after bit 15; that bit alone can never reach 3,
    // so quotient bit 15 is always zero and is not computed.
    logic [1:0] rem [0:15];

    assign rem[0] = {1'b0, X[15]};

    genvar gi;
    generate
        for (gi = 0; gi < 15; gi++) begin : g_stage
            logic [2:0] partial;
            logic [2:0] reduced;
            logic       take;

            assign partial       = {rem[gi], X[14-gi]};
            assign reduced       = partial - 3'd3;
            assign take          = (partial >= 3'd3);
            assign Q[14-gi]      = take;
            assign rem[gi+1]     = take ? reduced[1:0] : partial[1:0];
        end
    endgenerate

    assign R = rem[15];

endmodule

// File: rtl/ternary_digit_serializer.sv
// Converts a 16-bit operand to base-3 trits, LSD first, over a valid/ready stream.
// Define TERNARY_LZS_EN to stop at the most significant nonzero trit.
module ternary_digit_serializer
    import ternary_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     IN_X,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [1:0]       DIGIT_out,
    output logic             digit_valid,
    input  logic             digit_ready,
    output logic [IDX_W-1:0] digit_idx,
    output logic             digit_last
);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_LOAD = 2'(LOAD);
    localparam logic [1:0] ST_EMIT = 2'(EMIT);

    logic [1:0]       state_reg, state_next;
    logic [W-1:0]     work_reg,  work_next;
    trit_t            digit_reg, digit_next;
    logic             valid_reg, valid_next;
    logic [IDX_W-1:0] idx_reg,   idx_next;
    logic             last_reg,  last_next;

    logic [W-2:0]     core_q;
    trit_t            core_r;
    logic             step;

    div_16_3_stand u_div (
        .X (work_reg),
        .Q (core_q),
        .R (core_r)
    );

    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        digit_next = digit_reg;
        valid_next = valid_reg;
        idx_next   = idx_reg;
        last_next  = last_reg;
        step       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                valid_next = 1'b0;
                if (in_valid) begin
                    work_next  = IN_X;
                    idx_next   = '0;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                step       = 1'b1;
                state_next = ST_EMIT;
            end
            ST_EMIT: begin
                if (valid_reg && digit_ready) begin
                    if (last_reg) begin
                        valid_next = 1'b0;
                        state_next = ST_IDLE;
                    end else begin
                        step     = 1'b1;
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            default: begin
                valid_next = 1'b0;
                state_next = ST_IDLE;
            end
        endcase

        // Peel one trit off the working value; last-ness refers to the trit being loaded.
        if (step) begin
            digit_next = core_r;
            work_next  = {1'b0, core_q};
            valid_next = 1'b1;
`ifdef TERNARY_LZS_EN
            last_next  = (core_q == '0) || (idx_next == LAST_IDX);
`else
            last_next  = (idx_next == LAST_IDX);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            work_reg  <= '0;
            digit_reg <= '0;
            valid_reg <= 1'b0;
            idx_reg   <= '0;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            work_reg  <= work_next;
            digit_reg <= digit_next;
            valid_reg <= valid_next;
            idx_reg   <= idx_next;
            last_reg  <= last_next;
        end
    end

    assign in_ready    = (state_reg == ST_IDLE);
    assign DIGIT_out   = digit_reg;
    assign digit_valid = valid_reg;
    assign digit_idx   = idx_reg;
    assign digit_last  = last_reg;

endmodule
